mouse_cmd_arbiter: RTL

Shares the single PS/2 mouse transmitter/receiver pair between two command requesters: REQ0, the mouse init/master sequencer, and REQ1, the processor-side command port (sample rate, resolution, stream enable).
- Arbitrates with round-robin.
- Sends the granted byte and waits for the device acknowledge (0xFA).
- Handles resend (0xFE), receive errors and timeouts.
- Returns a completion pulse and status to the owning requester.
- Sits between the requesters and the transmitter/receiver control ports.

---
 rtl/mouse_cmd_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mouse_cmd_arbiter.sv
// mouse_cmd_arbiter: round-robin sharing of one PS/2 mouse transmitter/receiver pair between two command requesters.
// Optional macro MOUSE_ARB_RETRY_EN: on a resend request the latched byte is re-sent up to MAX_RETRY times.
module mouse_cmd_arbiter #(
   parameter int unsigned ACK_TIMEOUT = 2000000,
   parameter int unsigned MAX_RETRY   = 3,
   parameter logic [7:0]  ACK_BYTE    = 8'hFA,
   parameter logic [7:0]  RESEND_BYTE = 8'hFE
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0_VALID,
   input  logic [7:0] REQ0_BYTE,
   output logic       REQ0_GRANT,
   output logic       REQ0_DONE,
   input  logic       REQ1_VALID,
   input  logic [7:0] REQ1_BYTE,
   output logic       REQ1_GRANT,
   output logic       REQ1_DONE,
   output logic [1:0] DONE_STATUS,
   output logic       BUSY,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic       BYTE_READY,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_SENT, S_WAIT_ACK, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [1:0]      w_status;
   logic            w_pick;
   logic            w_expire;
   logic [TW-1:0]   r_timer;
   logic            r_owner;
   logic            r_last;
   logic [7:0]      r_byte;
   logic [1:0]      r_status;
   logic            r_send_byte, r_grant0, r_grant1, r_done0, r_done1, r_busy, r_read_en;
   logic            w_send_byte_d, w_grant0_d, w_grant1_d, w_done0_d, w_done1_d, w_busy_d, w_read_en_d;

`ifdef MOUSE_ARB_RETRY_EN
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0]   r_retry;
   logic            w_can_retry;
   assign w_can_retry = (r_retry < RW'(MAX_RETRY));
`else
   logic            w_unused_retry;
   assign w_unused_retry = ^MAX_RETRY;
`endif

   // Single requester wins outright; on contention the one not served last wins
   assign w_pick   = (REQ0_VALID && REQ1_VALID) ? ~r_last : REQ1_VALID;
   assign w_expire = (r_timer <= TW'(1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_status = 2'b00;
      case (r_state)
         S_IDLE:      if (REQ0_VALID || REQ1_VALID) w_next = S_SEND;
         S_SEND:      w_next = S_WAIT_SENT;
         S_WAIT_SENT: begin
            if (BYTE_SENT) w_next = S_WAIT_ACK;
            else if (w_expire) begin
               w_next   = S_DONE;
               w_status = 2'b10;
            end
         end
         S_WAIT_ACK: begin
            if (BYTE_READY) begin
               w_next = S_DONE;
               if (BYTE_ERROR_CODE != 2'b00)    w_status = 2'b11;
               else if (BYTE_READ == ACK_BYTE)  w_status = 2'b00;
               else if (BYTE_READ == RESEND_BYTE) begin
`ifdef MOUSE_ARB_RETRY_EN
                  if (w_can_retry) w_next   = S_SEND;
                  else             w_status = 2'b01;
`else
                  w_status = 2'b01;
`endif
               end
               else w_status = 2'b01;
            end
            else if (w_expire) begin
               w_next   = S_DONE;
               w_status = 2'b10;
            end
         end
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Output values for the state being entered; registered below so they line up with it
   always_comb begin
      w_send_byte_d = 1'b0;
      w_grant0_d    = 1'b0;
      w_grant1_d    = 1'b0;
      w_done0_d     = 1'b0;
      w_done1_d     = 1'b0;
      w_busy_d      = 1'b0;
      w_read_en_d   = 1'b0;
      w_send_byte_d = (w_next == S_SEND);
      w_grant0_d    = (r_state == S_IDLE) && (w_next == S_SEND) && !w_pick;
      w_grant1_d    = (r_state == S_IDLE) && (w_next == S_SEND) &&  w_pick;
      w_done0_d     = (w_next == S_DONE) && !r_owner;
      w_done1_d     = (w_next == S_DONE) &&  r_owner;
      w_busy_d      = (w_next != S_IDLE);
      w_read_en_d   = (w_next == S_WAIT_ACK);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_send_byte <= 1'b0;
         r_grant0    <= 1'b0;
         r_grant1    <= 1'b0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_busy      <= 1'b0;
         r_read_en   <= 1'b0;
         r_status    <= 2'b00;
         r_byte      <= 8'h00;
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_timer     <= '0;
      end else begin
         r_send_byte <= w_send_byte_d;
         r_grant0    <= w_grant0_d;
         r_grant1    <= w_grant1_d;
         r_done0     <= w_done0_d;
         r_done1     <= w_done1_d;
         r_busy      <= w_busy_d;
         r_read_en   <= w_read_en_d;
         if (w_next == S_DONE) r_status <= w_status;
         if (r_state == S_IDLE && w_next == S_SEND) begin
            r_owner <= w_pick;
            r_byte  <= w_pick ? REQ1_BYTE : REQ0_BYTE;
         end
         if (r_state == S_DONE) r_last <= r_owner;
         if ((w_next == S_WAIT_SENT && r_state != S_WAIT_SENT) ||
             (w_next == S_WAIT_ACK  && r_state != S_WAIT_ACK))
            r_timer <= TW'(ACK_TIMEOUT);
         else if (r_timer != '0)
            r_timer <= r_timer - TW'(1);
      end
   end

`ifdef MOUSE_ARB_RETRY_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                                         r_retry <= '0;
      else if (r_state == S_IDLE)                        r_retry <= '0;
      else if (r_state == S_WAIT_ACK && w_next == S_SEND) r_retry <= r_retry + RW'(1);
   end
`endif

   assign SEND_BYTE    = r_send_byte;
   assign BYTE_TO_SEND = r_byte;
   assign REQ0_GRANT   = r_grant0;
   assign REQ1_GRANT   = r_grant1;
   assign REQ0_DONE    = r_done0;
   assign REQ1_DONE    = r_done1;
   assign DONE_STATUS  = r_status;
   assign BUSY         = r_busy;
   assign READ_ENABLE  = r_read_en;

endmodule
